// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO controller: the I/O register map and the
// address slice that selects a register within the I/O window.
package mmio_pkg;

  typedef enum logic [1:0] {
    IO_STATUS  = 2'd0,
    IO_SWITCH  = 2'd1,
    IO_LED     = 2'd2,
    IO_DISPLAY = 2'd3
  } io_reg_e;

  localparam int REG_IDX_HI = 3;
  localparam int REG_IDX_LO = 2;

endpackage

// File: rtl/btn_debounce.sv
// One push button: two-flop synchroniser, stability-count debouncer and
// rising-edge detect on the debounced level.
module btn_debounce #(
  parameter int DB_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb,
  output logic rise
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic             deb_reg;
  logic             deb_q_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg  <= '0;
      deb_reg   <= 1'b0;
      deb_q_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync_reg  <= {sync_reg[0], raw};
      deb_q_reg <= deb_reg;
      // Any agreement restarts the count, so a bounce never accumulates.
      if (sync_reg[1] == deb_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_MAX) begin
        deb_reg <= sync_reg[1];
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign deb  = deb_reg;
  assign rise = deb_reg & ~deb_q_reg;

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller: splits data space between dmem and a
// 4-register I/O window (status, switches, LEDs, 7-segment display).
module mmio_io_ctrl
  import mmio_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int IO_SEL_BIT = 7,
  parameter int NUM_BTN    = 2,
  parameter int SW_W       = 16,
  parameter int LED_W      = 12,
  parameter int DB_CYCLES  = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              writeEn,
  input  logic              readEn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       writeData,
  output logic [31:0]       readData,
  output logic              memWe,
  input  logic [31:0]       memReadData,
  input  logic [NUM_BTN-1:0] btn,
  input  logic [SW_W-1:0]   switch,
  output logic [LED_W-1:0]  led,
  output logic [31:0]       display,
  output logic              btnPending
);

  logic         is_io;
  io_reg_e      reg_idx;
  logic         status_rd;
  logic         addr_unused;

  logic [SW_W-1:0]    sw_sync1_reg;
  logic [SW_W-1:0]    sw_sync2_reg;
  logic [LED_W-1:0]   led_reg;
  logic [31:0]        display_reg;
  logic [NUM_BTN-1:0] flag_reg;
  logic [NUM_BTN-1:0] rise_vec;
  logic [NUM_BTN-1:0] btn_deb_unused;

  assign is_io       = addr[IO_SEL_BIT];
  assign reg_idx     = io_reg_e'(addr[REG_IDX_HI:REG_IDX_LO]);
  assign status_rd   = readEn & is_io & (reg_idx == IO_STATUS);
  assign addr_unused = ^addr;

  assign memWe = writeEn & ~is_io;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
      ) u_btn_debounce (
        .clk  (clk),
        .reset(reset),
        .raw  (btn[gi]),
        .deb  (btn_deb_unused[gi]),
        .rise (rise_vec[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_sync1_reg <= '0;
      sw_sync2_reg <= '0;
      led_reg      <= '0;
      display_reg  <= '0;
      flag_reg     <= '0;
    end else begin
      sw_sync1_reg <= switch;
      sw_sync2_reg <= sw_sync1_reg;
      // A press landing on the clearing read survives: set has priority.
      flag_reg <= (flag_reg & ~{NUM_BTN{status_rd}}) | rise_vec;
      if (writeEn && is_io) begin
        case (reg_idx)
          IO_LED:     led_reg     <= writeData[LED_W-1:0];
          IO_DISPLAY: display_reg <= writeData;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    readData = memReadData;
    if (is_io) begin
      case (reg_idx)
        IO_STATUS:  readData = 32'(flag_reg);
        IO_SWITCH:  readData = 32'(sw_sync2_reg);
        IO_LED:     readData = 32'(led_reg);
        IO_DISPLAY: readData = display_reg;
        default:    readData = '0;
      endcase
    end
  end

  assign led        = led_reg;
  assign display    = display_reg;
  assign btnPending = |flag_reg;

endmodule
